// File: rtl/spi_mode2_target_if.sv
// rtl/spi_mode2_target_if.sv - bus bundle for the SPI mode-2 target
// Purpose: groups the SPI pins and the parallel word interface of spi_mode2_target.
// Signals:
//   cs_n_in, sck_in, mosi_in : SPI pins from the initiator (asynchronous to clk)
//   miso_out, miso_oe        : serial data back to the initiator and its output enable
//   rx_data, rx_valid        : last received word and its one-cycle update strobe
//   tx_data, tx_req          : next word to send and the one-cycle "consumed" strobe
// Modports: slave = the target block, master = the user/initiator side.
interface spi_mode2_target_if #(
  parameter int WIDTH = 8
);
  logic             cs_n_in;
  logic             sck_in;
  logic             mosi_in;
  logic             miso_out;
  logic             miso_oe;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_req;

  modport slave (
    input  cs_n_in, sck_in, mosi_in, tx_data,
    output miso_out, miso_oe, rx_data, rx_valid, tx_req
  );

  modport master (
    output cs_n_in, sck_in, mosi_in, tx_data,
    input  miso_out, miso_oe, rx_data, rx_valid, tx_req
  );
endinterface

// File: rtl/spi_mode2_target.sv
// rtl/spi_mode2_target.sv - SPI mode-2 (CPOL=1, CPHA=0) target with oversampled inputs
// Purpose: synchronises cs_n/sck/mosi into clk, detects sck edges, deserialises MSB-first
//          words onto rx_data/rx_valid and serialises tx_data back on miso.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : spi_mode2_target_if.slave (SPI pins plus rx/tx word interface)
// Parameters: WIDTH bits per word (2..32), SYNC_STAGES flops per synchroniser (>= 2).
module spi_mode2_target #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  spi_mode2_target_if.slave   bus
);
  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic                   cs_prev, sck_prev;
  logic                   cs_s, sck_s, mosi_s;
  logic                   cs_fall, sck_fall, sck_rise;

  logic                   do_load, do_abort, do_sample, do_shift, word_done;

  logic [CW-1:0]          count;
  logic                   reload;
  logic [WIDTH-2:0]       rx_shift;
  logic [WIDTH-1:0]       rx_next;
  logic [WIDTH-1:0]       tx_shift;
  logic                   miso_q, oe_q, rx_valid_q, tx_req_q;
  logic [WIDTH-1:0]       rx_data_q;

  // Synchronisers reset to the bus idle levels so no false edge appears on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '1;
      sck_sync  <= '1;
      mosi_sync <= '0;
      cs_prev   <= 1'b1;
      sck_prev  <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n_in};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi_in};
      cs_prev   <= cs_sync[SYNC_STAGES-1];
      sck_prev  <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_prev & ~cs_s;
  assign sck_fall = sck_prev & ~sck_s;
  assign sck_rise = ~sck_prev & sck_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (cs_s)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Deselect has priority over any sck edge seen in the same cycle.
  always_comb begin
    do_load   = (state == IDLE) && cs_fall;
    do_abort  = (state == ACTIVE) && cs_s;
    do_sample = (state == ACTIVE) && !cs_s && sck_fall;
    do_shift  = (state == ACTIVE) && !cs_s && sck_rise;
    word_done = do_sample && (count == LAST);
  end

  assign rx_next = {rx_shift, mosi_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      reload     <= 1'b0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (do_load) begin
        tx_shift <= bus.tx_data;
        miso_q   <= bus.tx_data[WIDTH-1];
        oe_q     <= 1'b1;
        count    <= '0;
        reload   <= 1'b0;
        tx_req_q <= 1'b1;
      end else if (do_abort) begin
        oe_q   <= 1'b0;
        miso_q <= 1'b0;
        count  <= '0;
        reload <= 1'b0;
      end else if (do_sample) begin
        rx_shift <= rx_next[WIDTH-2:0];
        if (word_done) begin
          rx_data_q  <= rx_next;
          rx_valid_q <= 1'b1;
          count      <= '0;
          // The next word is fetched on the following trailing edge, not here,
          // so the initiator still sees a stable last bit during this low phase.
          reload     <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end else if (do_shift) begin
        if (reload) begin
          tx_shift <= bus.tx_data;
          miso_q   <= bus.tx_data[WIDTH-1];
          tx_req_q <= 1'b1;
          reload   <= 1'b0;
        end else begin
          tx_shift <= tx_shift << 1;
          miso_q   <= tx_shift[WIDTH-2];
        end
      end
    end
  end

  assign bus.miso_out = miso_q;
  assign bus.miso_oe  = oe_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_req   = tx_req_q;
endmodule
